echo_delay_line: RTL and testbench
==================================

ECHO_DELAY_LINE -- requirements
Module: echo_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 12, sample width in bits (signed, two's complement).
REQ-002 SHALL have parameter ADDR_BITS, default 13, delay memory depth = 2^ADDR_BITS samples.
REQ-003 SHALL have parameter SAMPLES, default 240, samples per delay step (10 ms at 24 kHz).
REQ-004 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: ready  in  1  one-cycle pulse, new incoming_sample valid.
REQ-007 SHALL have ports: incoming_sample  in  WIDTH  signed input sample.
REQ-008 SHALL have ports: delay_amount  in  5  delay in steps of SAMPLES; 0 = bypass.
REQ-009 SHALL have ports: mode  in  1  0 = feed-forward (single echo), 1 = feedback (repeating echo).
REQ-010 SHALL have ports: gain_shift  in  3  echo attenuation, arithmetic right shift 0..7.
REQ-011 SHALL have ports: modified_sample  out  WIDTH  signed processed sample, registered.
REQ-012 SHALL have ports: done  out  1  one-cycle pulse, modified_sample updated.
REQ-013 SHALL have ports: busy  out  1  high while a sample is in process.

Function
REQ-014 SHALL use states IDLE, READ, CALC, WRITE; IDLE->READ on ready, READ->CALC, CALC->WRITE, WRITE->IDLE unconditionally.
REQ-015 SHALL latch incoming_sample, delay_amount, mode, gain_shift on the edge ready is accepted; later input changes SHALL not affect that sample.
REQ-016 SHALL ignore ready when state is not IDLE; busy = (state != IDLE).
REQ-017 Delay length D = delay_amount*SAMPLES, clamped to 2^ADDR_BITS-1; read address = wr_ptr - D modulo 2^ADDR_BITS.
REQ-018 Memory read latency is one cycle; delayed value is sampled in CALC.
REQ-019 Delayed value SHALL be treated as zero while fill count < D (memory never pre-cleared).
REQ-020 wet = delayed >>> gain_shift; sum = incoming + wet computed at WIDTH+1 bits, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 In WRITE: modified_sample <= saturated sum; memory[wr_ptr] <= incoming (mode 0) or saturated sum (mode 1); wr_ptr increments with wrap; done = 1.
REQ-022 Latency: ready high at edge N -> done high for exactly the cycle after edge N+3; next ready accepted at edge N+4.
REQ-023 Fill count SHALL increment per written sample and saturate at 2^ADDR_BITS.
REQ-024 delay_amount = 0: SHALL go IDLE->WRITE path with modified_sample = incoming_sample unchanged, still writing incoming to memory, done at same latency as REQ-022.
REQ-025 Changing delay_amount between samples SHALL take effect on next accepted sample; no flush.

Reset
REQ-026 On reset low, immediately: state IDLE, wr_ptr 0, fill count 0, modified_sample 0, done 0, busy 0; memory write enable 0.
REQ-027 Reset mid-operation SHALL abort the sample: no done pulse, no memory write.

Structure
REQ-028 State encoding, mode constants and saturation width helper SHALL live in shared package echo_pkg.
REQ-029 Delay storage SHALL be one instance of existing sub-module mybram (LOGSIZE=ADDR_BITS, WIDTH=WIDTH).

Verification
REQ-030 Bypass: delay_amount 0, sample 0x123 -> modified_sample 0x123, done 4 cycles after ready.
REQ-031 Feed-forward, SAMPLES=4, delay 1, gain 0: impulse 100 then zeros -> outputs 100 at n=0, 100 at n=4, 0 elsewhere (n=1..3 zero, no stale memory).
REQ-032 Feedback, SAMPLES=4, delay 1, gain 1: impulse 1024 -> outputs 1024, 512, 256, 128 at n=0,4,8,12.
REQ-033 Saturation: current 2000 with delayed 2000, gain 0 -> 2047; -2000 with -2000 -> -2048.
REQ-034 Ready re-pulsed in READ and CALC -> ignored, exactly one done; reset low during CALC -> no done, modified_sample 0, next sample sees fill 0.

Source files
------------

// File: rtl/echo_pkg.sv
// echo_pkg: shared definitions for the echo delay line.
//   state_t     - sample-processing FSM states
//   MODE_*      - echo mode constants (feed-forward / feedback)
//   sum_width() - width of the unsaturated dry+wet sum for a given sample width
package echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CALC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic MODE_FF = 1'b0;  // single echo: store the dry input
  localparam logic MODE_FB = 1'b1;  // repeating echo: store the mixed output

  // One guard bit is enough to hold the sum of two WIDTH-bit signed values.
  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/mybram.sv
// mybram: simple dual-port RAM, one write port and one read port, one-cycle
// registered read. Contents are never cleared.
//   clock  - write and read clock
//   we     - write enable
//   waddr  - write address
//   din    - write data
//   raddr  - read address
//   dout   - read data, valid the cycle after raddr is presented
module mybram #(
  parameter int LOGSIZE = 13,
  parameter int WIDTH   = 12
) (
  input  logic               clock,
  input  logic               we,
  input  logic [LOGSIZE-1:0] waddr,
  input  logic [WIDTH-1:0]   din,
  input  logic [LOGSIZE-1:0] raddr,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] mem_r [0:(1<<LOGSIZE)-1];

  // Storage write and registered read.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= din;
    end
    dout <= mem_r[raddr];
  end

endmodule

// File: rtl/echo_delay_line.sv
// echo_delay_line: audio echo effect. Each accepted sample is mixed with an
// attenuated copy of the sample D = delay_amount*SAMPLES positions earlier.
//   clock           - sole clock, rising edge
//   reset           - asynchronous, active-low reset
//   ready           - one-cycle pulse, incoming_sample valid (ignored while busy)
//   incoming_sample - signed input sample
//   delay_amount    - delay in steps of SAMPLES; 0 = bypass
//   mode            - 0 feed-forward (single echo), 1 feedback (repeating echo)
//   gain_shift      - echo attenuation as arithmetic right shift
//   modified_sample - registered signed output sample
//   done            - one-cycle pulse, modified_sample updated
//   busy            - high while a sample is in process
module echo_delay_line
  import echo_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int ADDR_BITS = 13,
  parameter int SAMPLES   = 240
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  input  logic signed [WIDTH-1:0] incoming_sample,
  input  logic [4:0]              delay_amount,
  input  logic                    mode,
  input  logic [2:0]              gain_shift,
  output logic signed [WIDTH-1:0] modified_sample,
  output logic                    done,
  output logic                    busy
);

  localparam int SW    = sum_width(WIDTH);
  localparam int MAX_D = (1 << ADDR_BITS) - 1;
  localparam logic [ADDR_BITS:0]       FILL_MAX = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic signed [WIDTH-1:0]  SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]  SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                  state_r, state_s;
  logic signed [WIDTH-1:0] sample_r;
  logic [4:0]              delay_r;
  logic                    mode_r;
  logic [2:0]              gain_r;
  logic signed [WIDTH-1:0] sum_r;
  logic [ADDR_BITS-1:0]    wr_ptr_r;
  logic [ADDR_BITS:0]      fill_r;

  logic [31:0]             prod_s;
  logic [ADDR_BITS-1:0]    dlen_s;
  logic [ADDR_BITS-1:0]    rd_addr_s;
  logic [WIDTH-1:0]        rd_data_s;
  logic signed [WIDTH-1:0] delayed_s;
  logic signed [WIDTH-1:0] wet_s;
  logic signed [SW-1:0]    dry_ext_s;
  logic signed [SW-1:0]    wet_ext_s;
  logic signed [SW-1:0]    sum_s;
  logic signed [WIDTH-1:0] sat_s;
  logic                    we_s;
  logic [WIDTH-1:0]        wr_data_s;

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: ready only matters in IDLE, the rest is a fixed sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  begin
        if (ready) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ:  state_s = ST_CALC;
      ST_CALC:  state_s = ST_WRITE;
      ST_WRITE: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  assign busy = (state_r != ST_IDLE);

  // Delay length in samples, clamped to what the memory can hold.
  always_comb begin
    prod_s = 32'(delay_r) * 32'(SAMPLES);
    if (prod_s > 32'(MAX_D)) begin
      dlen_s = ADDR_BITS'(MAX_D);
    end else begin
      dlen_s = prod_s[ADDR_BITS-1:0];
    end
  end

  assign rd_addr_s = wr_ptr_r - dlen_s;

  // Echo mix: memory contents are only trusted once D samples have been
  // written since reset, and bypass never uses the memory at all.
  always_comb begin
    if ((delay_r != 5'd0) && (fill_r >= {1'b0, dlen_s})) begin
      delayed_s = rd_data_s;
    end else begin
      delayed_s = '0;
    end
    wet_s     = delayed_s >>> gain_r;
    dry_ext_s = {sample_r[WIDTH-1], sample_r};
    wet_ext_s = {wet_s[WIDTH-1], wet_s};
    sum_s     = dry_ext_s + wet_ext_s;
    // Overflow shows up as the guard bit disagreeing with the WIDTH sign bit.
    if (sum_s[SW-1] != sum_s[SW-2]) begin
      sat_s = sum_s[SW-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_s = sum_s[WIDTH-1:0];
    end
  end

  assign we_s      = (state_r == ST_WRITE);
  assign wr_data_s = (mode_r == MODE_FB) ? sum_r : sample_r;

  // Input latch, mix register, write pointer, fill count and outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_r        <= '0;
      delay_r         <= 5'd0;
      mode_r          <= MODE_FF;
      gain_r          <= 3'd0;
      sum_r           <= '0;
      wr_ptr_r        <= '0;
      fill_r          <= '0;
      modified_sample <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state_r == ST_IDLE) && ready) begin
        sample_r <= incoming_sample;
        delay_r  <= delay_amount;
        mode_r   <= mode;
        gain_r   <= gain_shift;
      end
      if (state_r == ST_CALC) begin
        sum_r <= sat_s;
      end
      if (state_r == ST_WRITE) begin
        modified_sample <= sum_r;
        done            <= 1'b1;
        wr_ptr_r        <= wr_ptr_r + ADDR_BITS'(1);
        if (fill_r != FILL_MAX) begin
          fill_r <= fill_r + (ADDR_BITS+1)'(1);
        end
      end
    end
  end

  mybram #(
    .LOGSIZE (ADDR_BITS),
    .WIDTH   (WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .din   (wr_data_s),
    .raddr (rd_addr_s),
    .dout  (rd_data_s)
  );

endmodule

// File: tb/tb_echo_delay_line.sv
module tb_echo_delay_line;

  localparam int W     = 12;
  localparam int AB    = 6;
  localparam int SPS   = 4;
  localparam int MAXD  = (1 << AB) - 1;
  localparam int SMAX  = 2047;
  localparam int SMIN  = -2048;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                ready = 1'b0;
  logic signed [W-1:0] incoming_sample = '0;
  logic [4:0]          delay_amount = 5'd0;
  logic                mode = 1'b0;
  logic [2:0]          gain_shift = 3'd0;
  logic signed [W-1:0] modified_sample;
  logic                done;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;
  int hist[$];  // every value written to the delay memory since reset, oldest first

  echo_delay_line #(.WIDTH(W), .ADDR_BITS(AB), .SAMPLES(SPS)) dut (
    .clock           (clock),
    .reset           (reset),
    .ready           (ready),
    .incoming_sample (incoming_sample),
    .delay_amount    (delay_amount),
    .mode            (mode),
    .gain_shift      (gain_shift),
    .modified_sample (modified_sample),
    .done            (done),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  // Reference: expected output of the next sample from the write history.
  function automatic int model_out(input int x, input int d, input int g);
    int dl, dd, s;
    dd = d * SPS;
    if (dd > MAXD) dd = MAXD;
    if (d != 0 && hist.size() >= dd) dl = hist[hist.size() - dd];
    else dl = 0;
    s = x + (dl >>> g);
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    return s;
  endfunction

  task automatic scramble_inputs();
    incoming_sample = W'($urandom);
    delay_amount    = 5'($urandom);
    mode            = 1'($urandom);
    gain_shift      = 3'($urandom);
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_sample(input int x, input int d, input int m, input int g, output int got);
    int exp_v, lat;
    bit seen;
    logic signed [W-1:0] exp_s;
    exp_v = model_out(x, d, g);
    exp_s = exp_v[W-1:0];
    incoming_sample = x[W-1:0];
    delay_amount    = d[4:0];
    mode            = m[0];
    gain_shift      = g[2:0];
    ready = 1'b1;
    @(posedge clock);
    #1;
    ready = 1'b0;
    scramble_inputs();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_accept: got %b expected 1", busy);
    end
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat = k;
      end
    end
    n_cmp++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL latency: got %0d cycles expected 4 (x=%0d d=%0d)", lat, x, d);
    end
    n_cmp++;
    if (modified_sample !== exp_s) begin
      n_err++;
      $display("FAIL sample_value: got %0d expected %0d (x=%0d d=%0d m=%0d g=%0d)",
               modified_sample, exp_v, x, d, m, g);
    end
    got = int'(modified_sample);
    hist.push_back(m != 0 ? exp_v : x);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    ready = 1'b0;
    hist.delete();
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (modified_sample !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got sample=%0d done=%b busy=%b expected 0/0/0",
               modified_sample, done, busy);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_bypass();
    int got;
    apply_reset();
    do_sample(32'h123, 0, 0, 0, got);
    n_cmp++;
    if (got != 32'h123) begin
      n_err++;
      $display("FAIL bypass_value: got %0h expected 123", got);
    end
    do_sample(-700, 0, 1, 3, got);
  endtask

  task automatic test_random();
    int got, x, d;
    for (int i = 0; i < 300; i++) begin
      x = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 31));
      else d = int'($urandom_range(0, 3));
      do_sample(x, d, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), got);
    end
    do_sample(1000, 31, 0, 1, got);  // clamped delay path
  endtask

  task automatic test_feedforward();
    int got;
    apply_reset();
    for (int n = 0; n < 8; n++) begin
      do_sample(n == 0 ? 100 : 0, 1, 0, 0, got);
      n_cmp++;
      if (got != ((n % 4 == 0) ? 100 : 0)) begin
        n_err++;
        $display("FAIL feedforward_n%0d: got %0d expected %0d", n, got, (n % 4 == 0) ? 100 : 0);
      end
    end
  endtask

  task automatic test_feedback();
    int got;
    apply_reset();
    for (int n = 0; n < 13; n++) begin
      do_sample(n == 0 ? 1024 : 0, 1, 1, 1, got);
      if (n % 4 == 0) begin
        n_cmp++;
        if (got != (1024 >> (n / 4))) begin
          n_err++;
          $display("FAIL feedback_n%0d: got %0d expected %0d", n, got, 1024 >> (n / 4));
        end
      end
    end
  endtask

  task automatic test_saturation();
    int got;
    for (int p = 0; p < 2; p++) begin
      apply_reset();
      do_sample(p == 0 ? 2000 : -2000, 1, 0, 0, got);
      for (int n = 0; n < 3; n++) do_sample(0, 1, 0, 0, got);
      do_sample(p == 0 ? 2000 : -2000, 1, 0, 0, got);
      n_cmp++;
      if (got != (p == 0 ? 2047 : -2048)) begin
        n_err++;
        $display("FAIL saturation_%0d: got %0d expected %0d", p, got, p == 0 ? 2047 : -2048);
      end
    end
  endtask

  task automatic test_ignore_ready();
    int exp_v, dones, got;
    exp_v = model_out(321, 1, 2);
    incoming_sample = 12'sd321;
    delay_amount = 5'd1;
    mode = 1'b0;
    gain_shift = 3'd2;
    ready = 1'b1;
    @(posedge clock);
    #1;
    dones = 0;
    got = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 3) ready = 1'b0;  // ready was high at the READ and CALC edges
      if (done === 1'b1) begin
        dones++;
        got = int'(modified_sample);
      end
    end
    hist.push_back(321);
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL ignore_ready_dones: got %0d expected 1", dones);
    end
    n_cmp++;
    if (got != exp_v) begin
      n_err++;
      $display("FAIL ignore_ready_value: got %0d expected %0d", got, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    int dones, got;
    incoming_sample = 12'sd900;
    delay_amount = 5'd1;
    mode = 1'b1;
    gain_shift = 3'd0;
    ready = 1'b1;
    @(posedge clock);
    #1;
    ready = 1'b0;
    @(negedge clock);  // READ
    @(negedge clock);  // CALC
    reset = 1'b0;
    hist.delete();
    #1;
    n_cmp++;
    if (done !== 1'b0 || modified_sample !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got done=%b sample=%0d busy=%b expected 0/0/0",
               done, modified_sample, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: got %0d expected 0", dones);
    end
    // memory is dirty from earlier traffic; fill count 0 must hide it
    do_sample(10, 1, 0, 0, got);
    n_cmp++;
    if (got != 10) begin
      n_err++;
      $display("FAIL reset_mid_fill: got %0d expected 10", got);
    end
    for (int n = 1; n < 6; n++) do_sample(n * 7, 1, 0, 1, got);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_random();
    test_feedforward();
    test_feedback();
    test_saturation();
    test_random();
    test_ignore_ready();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
